unidade_busca: RTL and testbench

Instruction fetch and sequencing unit for the 3-bit-opcode processor. It drives the instruction-memory read handshake and holds the current instruction in an instruction register. The register's opcode field feeds `unidade_controle`. When the datapath reports completion, the block samples that unit's `Beqz`, `Ji` and `EscPC` outputs, together with the ALU zero flag, and computes the next PC.

---
 rtl/unidade_busca.sv | 108 ++++++++++
 tb/tb_unidade_busca.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// Instruction fetch and sequencing unit: drives the instruction-memory read
// handshake, holds the instruction register and computes the next PC on retirement.
module unidade_busca #(
    parameter int LARG_PC    = 13,
    parameter int LARG_INSTR = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [LARG_PC-1:0]    MemEnd,
    output logic                  MemReq,
    input  logic                  MemAck,
    input  logic [LARG_INSTR-1:0] MemDado,
    output logic [LARG_INSTR-1:0] Instrucao,
    output logic [2:0]            Opcode,
    output logic                  Valida,
    input  logic                  Concluido,
    input  logic                  Beqz,
    input  logic                  Ji,
    input  logic                  EscPC,
    input  logic                  Zero,
    output logic [LARG_PC-1:0]    PC,
    output logic                  Parado,
    output logic [15:0]           ContInstr
);

    typedef enum logic [1:0] {
        BUSCA  = 2'd0,
        EXEC   = 2'd1,
        PARADO = 2'd2
    } estado_t;

    estado_t               r_estado;
    logic [LARG_PC-1:0]    r_pc;
    logic [LARG_INSTR-1:0] r_instr;
    logic [15:0]           r_cont;

    logic [LARG_PC-1:0]    w_pc_mais1;
    logic [LARG_PC-1:0]    w_desvio;
    logic [LARG_PC-1:0]    w_alvo;
    logic [LARG_PC-1:0]    w_prox_pc;

    // Offset is sign-extended to PC width so the sum wraps modulo 2^LARG_PC.
    assign w_pc_mais1 = r_pc + LARG_PC'(1);
    assign w_desvio   = LARG_PC'($signed(r_instr[6:0]));
    assign w_alvo     = LARG_PC'(r_instr[12:0]);

    // Next-PC selection: jump beats a taken branch, otherwise sequential.
    always_comb begin
        w_prox_pc = w_pc_mais1;
        if (Ji) begin
            w_prox_pc = w_alvo;
        end else if (Beqz && Zero) begin
            w_prox_pc = w_pc_mais1 + w_desvio;
        end else begin
            w_prox_pc = w_pc_mais1;
        end
    end

    // Fetch/execute/halt sequencer with PC, instruction register and retire count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= BUSCA;
            r_pc     <= '0;
            r_instr  <= '0;
            r_cont   <= 16'd0;
        end else begin
            case (r_estado)
                BUSCA: begin
                    if (MemAck) begin
                        r_instr  <= MemDado;
                        r_estado <= EXEC;
                    end else begin
                        r_estado <= BUSCA;
                    end
                end
                EXEC: begin
                    if (Concluido) begin
                        r_cont <= r_cont + 16'd1;
                        if (!EscPC) begin
                            r_estado <= PARADO;
                        end else begin
                            r_pc     <= w_prox_pc;
                            r_estado <= BUSCA;
                        end
                    end else begin
                        r_estado <= EXEC;
                    end
                end
                PARADO: begin
                    r_estado <= PARADO;
                end
                default: begin
                    r_estado <= BUSCA;
                end
            endcase
        end
    end

    assign MemEnd    = r_pc;
    assign PC        = r_pc;
    assign Instrucao = r_instr;
    assign Opcode    = r_instr[15:13];
    assign ContInstr = r_cont;
    assign MemReq    = (r_estado == BUSCA);
    assign Valida    = (r_estado == EXEC);
    assign Parado    = (r_estado == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: a driver plays memory and datapath, a
// reference model predicts each fetched instruction, a monitor checks on EXEC entry.
module tb_unidade_busca;

    localparam int MODPC = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] MemEnd;
    logic        MemReq;
    logic        MemAck = 1'b0;
    logic [15:0] MemDado = 16'd0;
    logic [15:0] Instrucao;
    logic [2:0]  Opcode;
    logic        Valida;
    logic        Concluido = 1'b0;
    logic        Beqz = 1'b0;
    logic        Ji = 1'b0;
    logic        EscPC = 1'b0;
    logic        Zero = 1'b0;
    logic [12:0] PC;
    logic        Parado;
    logic [15:0] ContInstr;

    unidade_busca #(.LARG_PC(13), .LARG_INSTR(16)) dut (
        .clock(clock), .reset(reset), .MemEnd(MemEnd), .MemReq(MemReq),
        .MemAck(MemAck), .MemDado(MemDado), .Instrucao(Instrucao), .Opcode(Opcode),
        .Valida(Valida), .Concluido(Concluido), .Beqz(Beqz), .Ji(Ji), .EscPC(EscPC),
        .Zero(Zero), .PC(PC), .Parado(Parado), .ContInstr(ContInstr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          pc;
        logic [15:0] instr;
        logic [15:0] cont;
    } esperado_t;

    esperado_t   sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          pc_model = 0;
    logic [15:0] instr_model = 16'd0;
    logic [15:0] cont_model = 16'd0;
    logic        prev_valida = 1'b0;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        n_cmp++;
        if (atual !== esp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esp, $time);
        end
    endtask

    function automatic int next_pc(input int pc, input logic [15:0] w,
                                   input logic b, input logic j, input logic z);
        int off;
        if (j) return int'(w[12:0]) % MODPC;
        if (b && z) begin
            off = int'(w[6:0]);
            if (off > 63) off = off - 128;
            return ((pc + 1 + off) % MODPC + MODPC) % MODPC;
        end
        return (pc + 1) % MODPC;
    endfunction

    // Monitor: on every entry into EXEC, pop the predicted fetch and compare.
    always @(negedge clock) begin
        esperado_t   e;
        logic [15:0] w;
        if (reset) begin
            prev_valida <= 1'b0;
        end else begin
            if (Valida && !prev_valida) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_exec", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    w = e.instr;
                    chk("sb_pc", 32'(PC), 32'(e.pc));
                    chk("sb_instr", 32'(Instrucao), 32'(w));
                    chk("sb_opcode", 32'(Opcode), 32'(w[15:13]));
                    chk("sb_cont", 32'(ContInstr), 32'(e.cont));
                end
            end
            prev_valida <= Valida;
        end
    end

    // One instruction: fetch with 'waits' wait cycles, then EXEC for cdel+1 cycles.
    task automatic do_instr(input logic [15:0] word, input int waits, input int cdel,
                            input logic b, input logic j, input logic e, input logic z);
        esperado_t x;
        x.pc = pc_model; x.instr = word; x.cont = cont_model;
        sb_q.push_back(x);
        Beqz = 1'($urandom); Ji = 1'($urandom); Zero = 1'($urandom); EscPC = 1'($urandom);
        for (int i = 0; i <= waits; i++) begin
            Concluido = 1'($urandom);
            if (i == waits) begin
                MemAck = 1'b1; MemDado = word;
            end else begin
                MemAck = 1'b0; MemDado = 16'($urandom);
            end
            @(negedge clock);
            chk("busca_req", 32'(MemReq), 32'd1);
            chk("busca_end", 32'(MemEnd), 32'(pc_model));
            chk("busca_instr", 32'(Instrucao), 32'(instr_model));
            chk("busca_cont", 32'(ContInstr), 32'(cont_model));
            @(posedge clock); #1;
        end
        instr_model = word;
        Beqz = b; Ji = j; EscPC = e; Zero = z;
        for (int i = 0; i <= cdel; i++) begin
            Concluido = (i == cdel);
            MemAck = 1'($urandom); MemDado = 16'($urandom);
            @(negedge clock);
            chk("exec_valida", 32'(Valida), 32'd1);
            chk("exec_req", 32'(MemReq), 32'd0);
            chk("exec_pc", 32'(PC), 32'(pc_model));
            chk("exec_instr", 32'(Instrucao), 32'(word));
            @(posedge clock); #1;
        end
        Concluido = 1'b0; MemAck = 1'b0;
        cont_model = cont_model + 16'd1;
        if (e) pc_model = next_pc(pc_model, word, b, j, z);
    endtask

    initial begin
        logic [15:0] w;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        // Reset values.
        @(negedge clock);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_instr", 32'(Instrucao), 32'd0);
        chk("rst_cont", 32'(ContInstr), 32'd0);
        chk("rst_parado", 32'(Parado), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd1);
        chk("rst_valida", 32'(Valida), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Sequential, zero-wait, 2 cycles per instruction.
        for (int i = 0; i < 4; i++) begin
            w = {3'b000, 13'($urandom)};
            do_instr(w, 0, 0, 1'b0, 1'b0, 1'b1, 1'($urandom));
        end
        chk("seq_pc4", 32'(PC), 32'd4);
        chk("seq_cont4", 32'(ContInstr), 32'd4);
        do_instr(16'h1234, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("seq_pc5", 32'(PC), 32'd5);

        // Three wait cycles at PC=5; this instruction jumps to 10.
        w = {3'b101, 13'd10};
        do_instr(w, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("jmp_pc10", 32'(PC), 32'd10);

        // Branch taken / not taken with offset -2.
        w = {3'b011, 6'd0, 7'h7E};
        do_instr(w, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("beqz_taken", 32'(PC), 32'd9);
        w = {3'b101, 13'd10};
        do_instr(w, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        w = {3'b011, 6'd0, 7'h7E};
        do_instr(w, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("beqz_not_taken", 32'(PC), 32'd11);
        w = {3'b101, 13'd8190};
        do_instr(w, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("jmp_pc8190", 32'(PC), 32'd8190);
        w = {3'b011, 6'd0, 7'h3F};
        do_instr(w, 2, 2, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("beqz_wrap", 32'(PC), 32'd62);

        // Jump overrides branch.
        w = {3'b101, 13'h0100};
        do_instr(w, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("jmp_priority", 32'(PC), 32'd256);

        // Randomized instructions with stray inputs.
        for (int i = 0; i < 40; i++) begin
            do_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
        end

        // Halt at PC=20.
        w = {3'b101, 13'd20};
        do_instr(w, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("jmp_pc20", 32'(PC), 32'd20);
        do_instr(16'h0000, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            MemAck = 1'($urandom); Concluido = 1'($urandom); MemDado = 16'($urandom);
            @(negedge clock);
            chk("halt_parado", 32'(Parado), 32'd1);
            chk("halt_memreq", 32'(MemReq), 32'd0);
            chk("halt_valida", 32'(Valida), 32'd0);
            chk("halt_pc", 32'(PC), 32'd20);
            chk("halt_cont", 32'(ContInstr), 32'(cont_model));
            @(posedge clock); #1;
        end
        MemAck = 1'b0; Concluido = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        chk("areset_parado", 32'(Parado), 32'd0);
        chk("areset_pc", 32'(PC), 32'd0);
        chk("areset_cont", 32'(ContInstr), 32'd0);
        chk("areset_memreq", 32'(MemReq), 32'd1);
        chk("areset_instr", 32'(Instrucao), 32'd0);
        pc_model = 0; cont_model = 16'd0; instr_model = 16'd0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom), 1'b0, 1'b1, 1'($urandom));
        end
        @(negedge clock);
        chk("sb_final_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
